// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller for a 5-stage in-order core.
// Latency: control outputs are combinational from inputs + FSM state; counters/FSM update on clk rise.
// Backpressure: a dmem wait freezes every stage; load-use and imem waits hold PC/IFID and bubble IDEX.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   IFID_rs1/rs2, IFID_uses_rs1/2  sources read by the instruction in ID
//   IDEX_rd, IDEX_mem_read         destination / load flag of the instruction in EX
//   EX_br_taken                    branch or jump in EX redirects the PC
//   EXMEM_mem_access, dmem_resp    MEM-stage dmem request and completion
//   imem_resp                      instruction memory returns a word
//   load_*                         pipeline register enables
//   bubble_ifid, bubble_idex       load a NOP instead of upstream data
//   load_use_cnt, mem_stall_cnt, flush_cnt  saturating performance counters
module hazard_stall_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IFID_rs1,
  input  logic [4:0]  IFID_rs2,
  input  logic        IFID_uses_rs1,
  input  logic        IFID_uses_rs2,
  input  logic [4:0]  IDEX_rd,
  input  logic        IDEX_mem_read,
  input  logic        EX_br_taken,
  input  logic        EXMEM_mem_access,
  input  logic        dmem_resp,
  input  logic        imem_resp,
  output logic        load_pc,
  output logic        load_ifid,
  output logic        load_idex,
  output logic        load_exmem,
  output logic        load_memwb,
  output logic        bubble_ifid,
  output logic        bubble_idex,
  output logic [15:0] load_use_cnt,
  output logic [15:0] mem_stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {FETCH = 1'b0, SQUASH = 1'b1} state_t;

  state_t      state_q;
  logic [15:0] load_use_cnt_q, load_use_cnt_d;
  logic [15:0] mem_stall_cnt_q, mem_stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic dmem_busy;
  logic load_use;
  logic flush;
  logic lu_stall;
  logic squash_release;

  assign dmem_busy = EXMEM_mem_access & ~dmem_resp;

  // x0 never carries a real dependency, and an unread source cannot hazard.
  assign load_use = IDEX_mem_read & (IDEX_rd != 5'd0) &
                    ((IFID_uses_rs1 & (IFID_rs1 == IDEX_rd)) |
                     (IFID_uses_rs2 & (IFID_rs2 == IDEX_rd)));

  assign flush    = ~dmem_busy & EX_br_taken;
  assign lu_stall = ~dmem_busy & ~EX_br_taken & load_use;

  // The word arriving while in SQUASH belongs to the abandoned path: accept it
  // into IFID as a bubble so the fetch pipe keeps moving.
  assign squash_release = (state_q == SQUASH) & imem_resp & ~dmem_busy;

  always_comb begin
    load_pc     = 1'b1;
    load_ifid   = 1'b1;
    load_idex   = 1'b1;
    load_exmem  = 1'b1;
    load_memwb  = 1'b1;
    bubble_ifid = 1'b0;
    bubble_idex = 1'b0;
    if (dmem_busy) begin
      load_pc    = 1'b0;
      load_ifid  = 1'b0;
      load_idex  = 1'b0;
      load_exmem = 1'b0;
      load_memwb = 1'b0;
    end else if (EX_br_taken) begin
      bubble_ifid = 1'b1;
      bubble_idex = 1'b1;
    end else if (load_use || !imem_resp) begin
      load_pc     = 1'b0;
      load_ifid   = 1'b0;
      bubble_idex = 1'b1;
    end
    if (squash_release) begin
      load_pc     = 1'b1;
      load_ifid   = 1'b1;
      bubble_ifid = 1'b1;
    end
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    load_use_cnt_d  = sat_inc(load_use_cnt_q, lu_stall);
    mem_stall_cnt_d = sat_inc(mem_stall_cnt_q, dmem_busy);
    flush_cnt_d     = sat_inc(flush_cnt_q, flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= FETCH;
      load_use_cnt_q  <= 16'd0;
      mem_stall_cnt_q <= 16'd0;
      flush_cnt_q     <= 16'd0;
    end else begin
      load_use_cnt_q  <= load_use_cnt_d;
      mem_stall_cnt_q <= mem_stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
      case (state_q)
        // Redirect while the fetch is still outstanding: that word is wrong-path.
        FETCH:   if (flush && !imem_resp) state_q <= SQUASH;
        // A fresh redirect keeps squashing; otherwise leave once the stale word lands.
        SQUASH:  if (squash_release && !EX_br_taken) state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign load_use_cnt  = load_use_cnt_q;
  assign mem_stall_cnt = mem_stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       macc;
    logic       dresp;
    logic       iresp;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [6:0] exp; // {pc, ifid, idex, exmem, memwb, bubble_ifid, bubble_idex}
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  in_t         cur;
  logic        load_pc, load_ifid, load_idex, load_exmem, load_memwb;
  logic        bubble_ifid, bubble_idex;
  logic [15:0] load_use_cnt, mem_stall_cnt, flush_cnt;
  logic [6:0]  ctrl_act;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: is a wrong-path fetch outstanding, and event tallies.
  bit m_sq;
  int m_lu, m_ms, m_fl;

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .IFID_rs1         (cur.rs1),
    .IFID_rs2         (cur.rs2),
    .IFID_uses_rs1    (cur.u1),
    .IFID_uses_rs2    (cur.u2),
    .IDEX_rd          (cur.rd),
    .IDEX_mem_read    (cur.mr),
    .EX_br_taken      (cur.br),
    .EXMEM_mem_access (cur.macc),
    .dmem_resp        (cur.dresp),
    .imem_resp        (cur.iresp),
    .load_pc          (load_pc),
    .load_ifid        (load_ifid),
    .load_idex        (load_idex),
    .load_exmem       (load_exmem),
    .load_memwb       (load_memwb),
    .bubble_ifid      (bubble_ifid),
    .bubble_idex      (bubble_idex),
    .load_use_cnt     (load_use_cnt),
    .mem_stall_cnt    (mem_stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  assign ctrl_act = {load_pc, load_ifid, load_idex, load_exmem, load_memwb, bubble_ifid, bubble_idex};

  function automatic in_t idle();
    in_t v = '0;
    v.dresp = 1'b1;
    v.iresp = 1'b1;
    return v;
  endfunction

  function automatic bit m_busy(input in_t v);
    return v.macc && !v.dresp;
  endfunction

  function automatic bit m_dep(input in_t v);
    bit hit1 = v.u1 && (v.rs1 == v.rd);
    bit hit2 = v.u2 && (v.rs2 == v.rd);
    return v.mr && (v.rd != 0) && (hit1 || hit2);
  endfunction

  // Control word chosen by stall class, then the stale-word acceptance overlay.
  function automatic logic [6:0] model_ctrl(input in_t v, input bit sq);
    logic [6:0] r;
    if (m_busy(v))                   r = 7'b00000_00;
    else if (v.br)                   r = 7'b11111_11;
    else if (m_dep(v) || !v.iresp)   r = 7'b00111_01;
    else                             r = 7'b11111_00;
    if (sq && v.iresp && !m_busy(v)) begin
      r[6] = 1'b1;
      r[5] = 1'b1;
      r[1] = 1'b1;
    end
    return r;
  endfunction

  function automatic bit model_next_sq(input in_t v, input bit sq);
    if (m_busy(v)) return sq;
    if (sq)        return v.br || !v.iresp;
    return v.br && !v.iresp;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "/load_use_cnt"},  {16'd0, load_use_cnt},  m_lu);
    chk({tag, "/mem_stall_cnt"}, {16'd0, mem_stall_cnt}, m_ms);
    chk({tag, "/flush_cnt"},     {16'd0, flush_cnt},     m_fl);
  endtask

  // One clock: check controls mid-cycle, advance the reference at the edge, check counters.
  task automatic cycle(input string tag, input logic [6:0] exp);
    bit nsq;
    @(negedge clk);
    chk({tag, "/ctrl"}, {25'd0, ctrl_act}, {25'd0, exp});
    nsq = model_next_sq(cur, m_sq);
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (m_busy(cur))     m_ms = (m_ms < 65535) ? m_ms + 1 : m_ms;
      else if (cur.br)     m_fl = (m_fl < 65535) ? m_fl + 1 : m_fl;
      else if (m_dep(cur)) m_lu = (m_lu < 65535) ? m_lu + 1 : m_lu;
      m_sq = nsq;
    end
    chk_counters(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_sq = 1'b0; m_lu = 0; m_ms = 0; m_fl = 0;
    chk_counters("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl[14];

  initial begin
    cur = idle();
    m_sq = 1'b0; m_lu = 0; m_ms = 0; m_fl = 0;

    // Reset state: counters clear, controls decode as FETCH.
    #1;
    chk_counters("por");
    chk("por/ctrl", {25'd0, ctrl_act}, {25'd0, 7'b11111_00});
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-cycle decode table (none of these redirect with a fetch outstanding).
    for (int i = 0; i < 14; i++) tbl[i].in = idle();
    tbl[0].exp = 7'b11111_00;
    tbl[1].in.mr = 1; tbl[1].in.rd = 5; tbl[1].in.rs2 = 5; tbl[1].in.u2 = 1; tbl[1].exp = 7'b00111_01;
    tbl[2].in.mr = 1; tbl[2].in.rd = 0; tbl[2].in.u1 = 1; tbl[2].in.u2 = 1; tbl[2].exp = 7'b11111_00;
    tbl[3].in.mr = 1; tbl[3].in.rd = 7; tbl[3].in.rs1 = 7; tbl[3].in.u1 = 0; tbl[3].exp = 7'b11111_00;
    tbl[4].in.mr = 1; tbl[4].in.rd = 7; tbl[4].in.rs1 = 7; tbl[4].in.u1 = 1; tbl[4].exp = 7'b00111_01;
    tbl[5].in.mr = 0; tbl[5].in.rd = 7; tbl[5].in.rs1 = 7; tbl[5].in.u1 = 1; tbl[5].exp = 7'b11111_00;
    tbl[6].in.iresp = 0; tbl[6].exp = 7'b00111_01;
    tbl[7].in.macc = 1; tbl[7].in.dresp = 0; tbl[7].exp = 7'b00000_00;
    tbl[8].in.macc = 1; tbl[8].exp = 7'b11111_00;
    tbl[9].in.br = 1; tbl[9].exp = 7'b11111_11;
    tbl[10].in.br = 1; tbl[10].in.mr = 1; tbl[10].in.rd = 3; tbl[10].in.rs1 = 3; tbl[10].in.u1 = 1;
    tbl[10].exp = 7'b11111_11;
    tbl[11].in.br = 1; tbl[11].in.macc = 1; tbl[11].in.dresp = 0; tbl[11].exp = 7'b00000_00;
    tbl[12].in.macc = 1; tbl[12].in.dresp = 0; tbl[12].in.mr = 1; tbl[12].in.rd = 2; tbl[12].in.rs2 = 2;
    tbl[12].in.u2 = 1; tbl[12].exp = 7'b00000_00;
    tbl[13].in.iresp = 0; tbl[13].in.mr = 1; tbl[13].in.rd = 9; tbl[13].in.rs2 = 9; tbl[13].in.u2 = 1;
    tbl[13].exp = 7'b00111_01;
    for (int i = 0; i < 14; i++) begin
      cur = tbl[i].in;
      cycle($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // Load-use inserts exactly one bubble.
    do_reset();
    cur = idle(); cur.mr = 1; cur.rd = 5; cur.rs2 = 5; cur.u2 = 1;
    cycle("lu/stall", 7'b00111_01);
    chk("lu/count", {16'd0, load_use_cnt}, 32'd1);
    cur = idle(); cur.rs2 = 5; cur.u2 = 1;
    cycle("lu/after", 7'b11111_00);
    chk("lu/count_hold", {16'd0, load_use_cnt}, 32'd1);

    // Dmem stall dominates a pending branch.
    do_reset();
    cur = idle(); cur.macc = 1; cur.dresp = 0; cur.br = 1;
    for (int i = 0; i < 3; i++) cycle($sformatf("dm%0d", i), 7'b00000_00);
    chk("dm/mem_stall", {16'd0, mem_stall_cnt}, 32'd3);
    chk("dm/flush0", {16'd0, flush_cnt}, 32'd0);
    cur.dresp = 1;
    cycle("dm/release", 7'b11111_11);
    chk("dm/flush1", {16'd0, flush_cnt}, 32'd1);

    // Squash of the wrong-path fetch.
    do_reset();
    cur = idle(); cur.br = 1; cur.iresp = 0;
    cycle("sq/redirect", 7'b11111_11);
    cur = idle(); cur.iresp = 0;
    cycle("sq/wait0", 7'b00111_01);
    cycle("sq/wait1", 7'b00111_01);
    cur.iresp = 1;
    cycle("sq/drop", 7'b11111_10);
    cycle("sq/fetch", 7'b11111_00);

    // Async reset while squashing discards the squash immediately.
    cur = idle(); cur.br = 1; cur.iresp = 0;
    cycle("ar/redirect", 7'b11111_11);
    cur = idle(); cur.iresp = 0;
    #3;
    rst_n = 1'b0;
    #1;
    cur.iresp = 1;
    #1;
    m_sq = 1'b0; m_lu = 0; m_ms = 0; m_fl = 0;
    chk_counters("ar/async");
    chk("ar/ctrl", {25'd0, ctrl_act}, {25'd0, 7'b11111_00});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("ar/no_bubble", 7'b11111_00);

    // Randomized traffic against the reference.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cur.rs1   = 5'($urandom_range(0, 3));
      cur.rs2   = 5'($urandom_range(0, 3));
      cur.rd    = 5'($urandom_range(0, 3));
      cur.u1    = 1'($urandom_range(0, 1));
      cur.u2    = 1'($urandom_range(0, 1));
      cur.mr    = 1'($urandom_range(0, 1));
      cur.br    = ($urandom_range(0, 4) == 0);
      cur.macc  = ($urandom_range(0, 3) == 0);
      cur.dresp = 1'($urandom_range(0, 1));
      cur.iresp = ($urandom_range(0, 2) != 0);
      cycle($sformatf("rnd%0d", i), model_ctrl(cur, m_sq));
    end

    // Saturation of the load-use counter.
    do_reset();
    cur = idle(); cur.mr = 1; cur.rd = 4; cur.rs1 = 4; cur.u1 = 1;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat/load_use_cnt", {16'd0, load_use_cnt}, 32'h0000_FFFF);
    chk("sat/ctrl", {25'd0, ctrl_act}, {25'd0, 7'b00111_01});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
